lsu_axi_rd_eng: RTL and testbench
=================================

# lsu_axi_rd_eng

Parametrised AXI read engine for the LSU load path (ld_iram / ld_wram). It accepts one load command and splits it into `num+1` strided INCR bursts of `len+1` beats each. It keeps up to `MAX_OUTS` bursts in flight and writes every returned beat into the target on-chip RAM at consecutive addresses. Compared with the fixed single-burst read path, it adds configurable widths, burst striding, outstanding-burst tracking and sticky error reporting.

## Interface
Parameters:
- `DATA_W`, 64, R data / RAM write width in bits; power of two, 8..1024
- `ADDR_W`, 31, DRAM byte-address width
- `RAM_AW`, 12, on-chip RAM word-address width
- `ID_W`, 8, AXI ID width
- `MAX_OUTS`, 4, maximum outstanding bursts; 1..15

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `cmd_vld`  in  1  load command valid
- `cmd_rdy`  out  1  engine idle, command accepted when both high
- `cmd_dram_addr`  in  ADDR_W  byte address of first burst
- `cmd_num`  in  8  number of bursts minus 1
- `cmd_len`  in  8  beats per burst minus 1 (driven onto arlen)
- `cmd_stride`  in  ADDR_W  byte offset between consecutive burst start addresses
- `cmd_ram_addr`  in  RAM_AW  first RAM word address
- `lsu_axi_arid`  out  ID_W  burst index modulo 2^ID_W
- `lsu_axi_araddr`  out  ADDR_W  burst start address
- `lsu_axi_arlen`  out  8  equals latched cmd_len
- `lsu_axi_arsize`  out  3  constant log2(DATA_W/8)
- `lsu_axi_arburst`  out  2  constant 2'b01 (INCR)
- `lsu_axi_arvld`  out  1  AR valid
- `axi_lsu_arrdy`  in  1  AR ready
- `axi_lsu_rid`  in  ID_W  R ID
- `axi_lsu_rdata`  in  DATA_W  R data
- `axi_lsu_rresp`  in  2  R response
- `axi_lsu_rlast`  in  1  last beat of burst
- `axi_lsu_rvld`  in  1  R valid
- `lsu_axi_rrdy`  out  1  R ready
- `ram_wr_en`  out  1  RAM write strobe
- `ram_wr_addr`  out  RAM_AW  RAM write address
- `ram_wr_data`  out  DATA_W  RAM write data
- `ld_done`  out  1  one-cycle pulse when the command completes
- `ld_err`  out  1  sticky error; cleared on next command accept

## Operation
- States:
  - IDLE: `cmd_rdy`=1, `rrdy`=0. Command handshake latches all fields and moves to RUN.
  - RUN: issues AR bursts and accepts R beats. Moves to DRAIN once the last AR handshake completes.
  - DRAIN: AR idle, accepts R beats. When `outs`=0, pulses `ld_done` and returns to IDLE.
- AR issue: `arvld` is high in RUN while `issued` ≤ num and `outs` < MAX_OUTS.
  - `araddr` = dram_addr + issued·stride, computed by accumulator modulo 2^ADDR_W.
  - `arid`, `araddr` and `arlen` are stable while `arvld`=1 and `arrdy`=0.
- Outstanding counter `outs`:
  - +1 on AR handshake.
  - −1 on an R handshake with rlast=1.
  - Both in the same cycle: unchanged.
- R handling: `rrdy`=1 in RUN and DRAIN, so there is no backpressure.
  - Each accepted beat writes `rdata` to `wptr`, then `wptr` increments.
  - `wptr` starts at cmd_ram_addr and wraps modulo 2^RAM_AW.
  - Burst completion is defined only by rlast; beats per burst are not counted.
- Errors: any accepted beat with rresp≠2'b00 sets `ld_err`. The data is still written.
- Reset mid-operation returns the engine to IDLE and clears all counters. In-flight AXI transactions are abandoned.

## Timing
- Reset values:
  - `cmd_rdy`=1.
  - `arvld`=0, `rrdy`=0.
  - `arid`, `araddr`, `arlen` = 0; `arsize` and `arburst` are constants.
  - `ram_wr_en`=0, `ram_wr_addr`=0, `ram_wr_data`=0.
  - `ld_done`=0, `ld_err`=0.
- Command accepted in cycle T: `cmd_rdy`=0 and `arvld`=1 at T+1.
- AR handshake at cycle t: the next burst's `arvld` can be high at t+1, giving back-to-back bursts.
- R beat accepted at t: `ram_wr_en`/`addr`/`data` are registered and valid at t+1.
- Final rlast accepted at t: `ld_done`=1 at t+1, and the last RAM write is also at t+1. `cmd_rdy`=1 at t+2.
- At most one command is in flight. `cmd_vld` during busy is held off by `cmd_rdy`=0.

## Configuration
- `LSU_RD_RID_CHECK_EN` defined:
  - The engine tracks the expected in-order ID, which is the completed-burst count modulo 2^ID_W.
  - A beat whose `rid` differs from the expected ID sets `ld_err`. The beat is still written.
- Undefined: `rid` is ignored.

## Test plan
- Single burst: num=0, len=3, addr=0x100, ram=0x010, arrdy=1, R at full rate. Expect one AR (araddr=0x100, arlen=3), writes at 0x010..0x013, `ld_done` one cycle after rlast, `ld_err`=0.
- Strided multi-burst: num=5, len=1, stride=0x40, MAX_OUTS=4, R delayed 10 cycles. Expect araddrs 0x000,0x040…0x140 with IDs 0..5, and at most 4 bursts outstanding. AR stalls until the first rlast returns. Expect 12 writes in order.
- Simultaneous AR handshake and rlast in the same cycle: `outs` unchanged, and no missing or extra AR.
- RAM wrap: ram=0xFFE, 4 beats. Expect write addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Error: rresp=2'b10 on beat 2. Data is still written and `ld_err` stays 1 after `ld_done`. `ld_err` clears on the next command accept.
- With `LSU_RD_RID_CHECK_EN`: return rid=3 when 0 is expected, which sets `ld_err`. Without the macro, `ld_err` stays 0. Also assert `rst_n` low mid-burst: all outputs return to reset values immediately.

Source files
------------

// File: rtl/lsu_axi_rd_eng_if.sv
// AXI read-address / read-data bundle between the LSU read engine (master) and the DRAM fabric (slave).
interface lsu_axi_rd_eng_if #(
    parameter int ADDR_W = 31,
    parameter int ID_W   = 8,
    parameter int DATA_W = 64
);
    logic [ID_W-1:0]   lsu_axi_arid;
    logic [ADDR_W-1:0] lsu_axi_araddr;
    logic [7:0]        lsu_axi_arlen;
    logic [2:0]        lsu_axi_arsize;
    logic [1:0]        lsu_axi_arburst;
    logic              lsu_axi_arvld;
    logic              axi_lsu_arrdy;
    logic [ID_W-1:0]   axi_lsu_rid;
    logic [DATA_W-1:0] axi_lsu_rdata;
    logic [1:0]        axi_lsu_rresp;
    logic              axi_lsu_rlast;
    logic              axi_lsu_rvld;
    logic              lsu_axi_rrdy;

    modport master (
        output lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize,
               lsu_axi_arburst, lsu_axi_arvld, lsu_axi_rrdy,
        input  axi_lsu_arrdy, axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp,
               axi_lsu_rlast, axi_lsu_rvld
    );

    modport slave (
        input  lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize,
               lsu_axi_arburst, lsu_axi_arvld, lsu_axi_rrdy,
        output axi_lsu_arrdy, axi_lsu_rid, axi_lsu_rdata, axi_lsu_rresp,
               axi_lsu_rlast, axi_lsu_rvld
    );
endinterface

// File: rtl/lsu_axi_rd_eng.sv
// LSU AXI read engine: splits one load command into num+1 strided INCR bursts and streams beats into RAM.
// Optional in-order R ID checking is enabled by defining LSU_RD_RID_CHECK_EN.
module lsu_axi_rd_eng #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 31,
    parameter int RAM_AW   = 12,
    parameter int ID_W     = 8,
    parameter int MAX_OUTS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_vld,
    output logic              cmd_rdy,
    input  logic [ADDR_W-1:0] cmd_dram_addr,
    input  logic [7:0]        cmd_num,
    input  logic [7:0]        cmd_len,
    input  logic [ADDR_W-1:0] cmd_stride,
    input  logic [RAM_AW-1:0] cmd_ram_addr,
    lsu_axi_rd_eng_if.master  axi,
    output logic              ram_wr_en,
    output logic [RAM_AW-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ld_done,
    output logic              ld_err
);
    localparam int OUTS_W = $clog2(MAX_OUTS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t              state_q, state_d;
    logic                cmd_rdy_q, cmd_rdy_d;
    logic                arvld_q, arvld_d;
    logic                rrdy_q, rrdy_d;
    logic [ID_W-1:0]     arid_q, arid_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [7:0]          arlen_q, arlen_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [7:0]          num_q, num_d;
    logic [8:0]          issued_q, issued_d;
    logic [OUTS_W-1:0]   outs_q, outs_d;
    logic [RAM_AW-1:0]   wptr_q, wptr_d;
    logic                wr_en_q, wr_en_d;
    logic [RAM_AW-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
`ifdef LSU_RD_RID_CHECK_EN
    logic [ID_W-1:0]     exp_rid_q, exp_rid_d;
`else
    logic                unused_rid;
    assign unused_rid = ^axi.axi_lsu_rid;
`endif

    logic cmd_acc, ar_hs, r_hs, r_last_hs;

    always_comb begin
        state_d   = state_q;
        cmd_rdy_d = cmd_rdy_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        stride_d  = stride_q;
        num_d     = num_q;
        issued_d  = issued_q;
        outs_d    = outs_q;
        wptr_d    = wptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = err_q;
`ifdef LSU_RD_RID_CHECK_EN
        exp_rid_d = exp_rid_q;
`endif

        cmd_acc   = cmd_vld && cmd_rdy_q;
        ar_hs     = arvld_q && axi.axi_lsu_arrdy;
        r_hs      = rrdy_q && axi.axi_lsu_rvld;
        r_last_hs = r_hs && axi.axi_lsu_rlast;

        // The address accumulator only advances on a handshake, keeping AR stable under backpressure.
        if (ar_hs) begin
            issued_d = issued_q + 9'd1;
            araddr_d = araddr_q + stride_q;
            arid_d   = arid_q + ID_W'(1);
        end

        case ({ar_hs, r_last_hs})
            2'b10:   outs_d = outs_q + OUTS_W'(1);
            2'b01:   outs_d = outs_q - OUTS_W'(1);
            default: outs_d = outs_q;
        endcase

        if (r_hs) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wptr_q;
            wr_data_d = axi.axi_lsu_rdata;
            wptr_d    = wptr_q + RAM_AW'(1);
            if (axi.axi_lsu_rresp != 2'b00)
                err_d = 1'b1;
        end

`ifdef LSU_RD_RID_CHECK_EN
        if (r_hs && (axi.axi_lsu_rid != exp_rid_q))
            err_d = 1'b1;
        if (r_last_hs)
            exp_rid_d = exp_rid_q + ID_W'(1);
`endif

        case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    state_d   = ST_RUN;
                    cmd_rdy_d = 1'b0;
                    araddr_d  = cmd_dram_addr;
                    arid_d    = '0;
                    arlen_d   = cmd_len;
                    stride_d  = cmd_stride;
                    num_d     = cmd_num;
                    issued_d  = '0;
                    outs_d    = '0;
                    wptr_d    = cmd_ram_addr;
                    err_d     = 1'b0;
`ifdef LSU_RD_RID_CHECK_EN
                    exp_rid_d = '0;
`endif
                end
            end
            ST_RUN: begin
                if (ar_hs && (issued_d > {1'b0, num_q}))
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Final rlast sets done; the cycle after, outs is zero and the engine frees up.
                if (r_last_hs && (outs_d == '0))
                    done_d = 1'b1;
                if (outs_q == '0) begin
                    state_d   = ST_IDLE;
                    cmd_rdy_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        arvld_d = (state_d == ST_RUN) && (issued_d <= {1'b0, num_d}) &&
                  (outs_d < OUTS_W'(MAX_OUTS));
        rrdy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cmd_rdy_q <= 1'b1;
            arvld_q   <= 1'b0;
            rrdy_q    <= 1'b0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            stride_q  <= '0;
            num_q     <= '0;
            issued_q  <= '0;
            outs_q    <= '0;
            wptr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef LSU_RD_RID_CHECK_EN
            exp_rid_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cmd_rdy_q <= cmd_rdy_d;
            arvld_q   <= arvld_d;
            rrdy_q    <= rrdy_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            stride_q  <= stride_d;
            num_q     <= num_d;
            issued_q  <= issued_d;
            outs_q    <= outs_d;
            wptr_q    <= wptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef LSU_RD_RID_CHECK_EN
            exp_rid_q <= exp_rid_d;
`endif
        end
    end

    assign cmd_rdy             = cmd_rdy_q;
    assign axi.lsu_axi_arid    = arid_q;
    assign axi.lsu_axi_araddr  = araddr_q;
    assign axi.lsu_axi_arlen   = arlen_q;
    assign axi.lsu_axi_arsize  = 3'($clog2(DATA_W / 8));
    assign axi.lsu_axi_arburst = 2'b01;
    assign axi.lsu_axi_arvld   = arvld_q;
    assign axi.lsu_axi_rrdy    = rrdy_q;
    assign ram_wr_en           = wr_en_q;
    assign ram_wr_addr         = wr_addr_q;
    assign ram_wr_data         = wr_data_q;
    assign ld_done             = done_q;
    assign ld_err              = err_q;
endmodule

// File: tb/tb_lsu_axi_rd_eng.sv
// Bench for lsu_axi_rd_eng: directed and random load commands against an AXI slave model and a scoreboard.
`timescale 1ns/1ps
module tb_lsu_axi_rd_eng;
    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 31;
    localparam int RAM_AW   = 12;
    localparam int ID_W     = 8;
    localparam int MAX_OUTS = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              cmd_vld, cmd_rdy;
    logic [ADDR_W-1:0] cmd_dram_addr, cmd_stride;
    logic [7:0]        cmd_num, cmd_len;
    logic [RAM_AW-1:0] cmd_ram_addr;
    logic              ram_wr_en;
    logic [RAM_AW-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              ld_done, ld_err;

    lsu_axi_rd_eng_if #(.ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_W(DATA_W)) axi ();

    lsu_axi_rd_eng #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_AW(RAM_AW), .ID_W(ID_W), .MAX_OUTS(MAX_OUTS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_dram_addr(cmd_dram_addr), .cmd_num(cmd_num), .cmd_len(cmd_len),
        .cmd_stride(cmd_stride), .cmd_ram_addr(cmd_ram_addr),
        .axi(axi),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ld_done(ld_done), .ld_err(ld_err)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave configuration and logs
    typedef struct { logic [ID_W-1:0] id; logic [7:0] len; int ready; } burst_t;
    burst_t pend_q[$];
    logic [ID_W-1:0]   ar_id_q[$];
    logic [ADDR_W-1:0] ar_addr_q[$];
    logic [7:0]        ar_len_q[$];
    logic [RAM_AW-1:0] wr_addr_q[$];
    logic [63:0]       wr_data_q[$];
    logic [63:0]       beat_data_q[$];

    int  rdelay = 0, err_beat = -1, drv_beat = 0;
    bit  arrdy_rand = 0, rid_bad = 0;
    int  outs_tb = 0, outs_max = 0, both_cnt = 0, done_cnt = 0;
    int  done_cyc = 0, last_beat_cyc = 0, exp_id_tb = 0;
    logic err_exp = 1'b0, done_err = 1'b0, rdy_at_done = 1'b0, rdy_after_done = 1'b0;
    bit  done_pending = 0, stall_prev = 0;
    logic [ID_W-1:0]   prev_id;
    logic [ADDR_W-1:0] prev_addr;
    logic [7:0]        prev_len;

    // Monitor: samples on the falling edge, when all inputs for the next rising edge are stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_q.delete();
            outs_tb = 0;
            stall_prev = 0;
            done_pending = 0;
        end else begin
            if (stall_prev) begin
                chk("ar_stall_vld", axi.lsu_axi_arvld, 1'b1);
                chk("ar_stall_id", axi.lsu_axi_arid, prev_id);
                chk("ar_stall_addr", axi.lsu_axi_araddr, prev_addr);
                chk("ar_stall_len", axi.lsu_axi_arlen, prev_len);
            end
            stall_prev = axi.lsu_axi_arvld && !axi.axi_lsu_arrdy;
            prev_id    = axi.lsu_axi_arid;
            prev_addr  = axi.lsu_axi_araddr;
            prev_len   = axi.lsu_axi_arlen;
            if (axi.lsu_axi_arvld && axi.axi_lsu_arrdy) begin
                ar_id_q.push_back(axi.lsu_axi_arid);
                ar_addr_q.push_back(axi.lsu_axi_araddr);
                ar_len_q.push_back(axi.lsu_axi_arlen);
                pend_q.push_back('{axi.lsu_axi_arid, axi.lsu_axi_arlen, cyc + 1 + rdelay});
                outs_tb++;
                if (axi.axi_lsu_rvld && axi.lsu_axi_rrdy && axi.axi_lsu_rlast) both_cnt++;
            end
            if (axi.axi_lsu_rvld && axi.lsu_axi_rrdy) begin
                beat_data_q.push_back(axi.axi_lsu_rdata);
                last_beat_cyc = cyc;
                if (axi.axi_lsu_rresp != 2'b00) err_exp = 1'b1;
`ifdef LSU_RD_RID_CHECK_EN
                if (axi.axi_lsu_rid != ID_W'(exp_id_tb)) err_exp = 1'b1;
`endif
                if (axi.axi_lsu_rlast) begin
                    outs_tb--;
                    exp_id_tb++;
                end
            end
            if (outs_tb > outs_max) outs_max = outs_tb;
            if (ram_wr_en) begin
                wr_addr_q.push_back(ram_wr_addr);
                wr_data_q.push_back(ram_wr_data);
            end
            if (done_pending) begin
                rdy_after_done = cmd_rdy;
                done_pending = 0;
            end
            if (ld_done) begin
                done_cnt++;
                done_cyc = cyc;
                done_err = ld_err;
                rdy_at_done = cmd_rdy;
                done_pending = 1;
            end
        end
    end

    // AXI slave: answers bursts in order after rdelay cycles, full-rate beats.
    initial begin
        burst_t cur;
        bit cur_valid;
        int cur_beat;
        cur_valid = 0;
        cur_beat = 0;
        axi.axi_lsu_arrdy = 1'b0;
        axi.axi_lsu_rvld  = 1'b0;
        axi.axi_lsu_rid   = '0;
        axi.axi_lsu_rdata = '0;
        axi.axi_lsu_rresp = 2'b00;
        axi.axi_lsu_rlast = 1'b0;
        forever begin
            @(posedge clk); #1;
            axi.axi_lsu_arrdy = arrdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!rst_n) begin
                cur_valid = 0;
                axi.axi_lsu_rvld = 1'b0;
                axi.axi_lsu_rlast = 1'b0;
                continue;
            end
            if (!cur_valid && pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
                cur = pend_q.pop_front();
                cur_valid = 1;
                cur_beat = 0;
            end
            if (cur_valid && axi.lsu_axi_rrdy) begin
                axi.axi_lsu_rvld  = 1'b1;
                axi.axi_lsu_rid   = (rid_bad && cur.id == '0) ? ID_W'(3) : cur.id;
                axi.axi_lsu_rdata = {$urandom, $urandom};
                axi.axi_lsu_rresp = (drv_beat == err_beat) ? 2'b10 : 2'b00;
                axi.axi_lsu_rlast = (cur_beat == int'(cur.len));
                drv_beat++;
                if (cur_beat == int'(cur.len)) cur_valid = 0;
                else cur_beat++;
            end else begin
                axi.axi_lsu_rvld  = 1'b0;
                axi.axi_lsu_rlast = 1'b0;
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_rdy"}, cmd_rdy, 1'b1);
        chk({tag, "_arvld"}, axi.lsu_axi_arvld, 1'b0);
        chk({tag, "_rrdy"}, axi.lsu_axi_rrdy, 1'b0);
        chk({tag, "_arid"}, axi.lsu_axi_arid, 0);
        chk({tag, "_araddr"}, axi.lsu_axi_araddr, 0);
        chk({tag, "_arlen"}, axi.lsu_axi_arlen, 0);
        chk({tag, "_arsize"}, axi.lsu_axi_arsize, 3);
        chk({tag, "_arburst"}, axi.lsu_axi_arburst, 1);
        chk({tag, "_wr_en"}, ram_wr_en, 1'b0);
        chk({tag, "_wr_addr"}, ram_wr_addr, 0);
        chk({tag, "_wr_data"}, ram_wr_data, 0);
        chk({tag, "_ld_done"}, ld_done, 1'b0);
        chk({tag, "_ld_err"}, ld_err, 1'b0);
    endtask

    task automatic issue_cmd(input logic [ADDR_W-1:0] addr, input logic [7:0] num, input logic [7:0] len,
                             input logic [ADDR_W-1:0] stride, input logic [RAM_AW-1:0] ram);
        int waited = 0;
        while (!cmd_rdy && waited < 1000) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("cmd_rdy_before_issue", cmd_rdy, 1'b1);
        cmd_dram_addr = addr;
        cmd_num = num;
        cmd_len = len;
        cmd_stride = stride;
        cmd_ram_addr = ram;
        cmd_vld = 1'b1;
        @(posedge clk); #1;
        cmd_vld = 1'b0;
    endtask

    task automatic run_cmd(input string name, input logic [ADDR_W-1:0] addr, input logic [7:0] num,
                           input logic [7:0] len, input logic [ADDR_W-1:0] stride,
                           input logic [RAM_AW-1:0] ram, input int delay, input bit rnd_rdy,
                           input int eb, input bit bad);
        int waited;
        int total;
        logic [ADDR_W-1:0] ea;
        logic [RAM_AW-1:0] ew;
        ar_id_q.delete(); ar_addr_q.delete(); ar_len_q.delete();
        wr_addr_q.delete(); wr_data_q.delete(); beat_data_q.delete();
        done_cnt = 0; outs_max = 0; both_cnt = 0; err_exp = 1'b0; exp_id_tb = 0; drv_beat = 0;
        rdelay = delay; arrdy_rand = rnd_rdy; err_beat = eb; rid_bad = bad;
        issue_cmd(addr, num, len, stride, ram);
        @(negedge clk);
        chk({name, "_cmd_rdy_busy"}, cmd_rdy, 1'b0);
        chk({name, "_arvld_first"}, axi.lsu_axi_arvld, 1'b1);
        chk({name, "_err_cleared"}, ld_err, 1'b0);
        waited = 0;
        while (done_cnt == 0 && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        arrdy_rand = 0;
        total = (int'(num) + 1) * (int'(len) + 1);
        chk({name, "_done_cnt"}, done_cnt, 1);
        chk({name, "_ar_count"}, ar_addr_q.size(), int'(num) + 1);
        for (int i = 0; i <= int'(num); i++) begin
            ea = addr + stride * ADDR_W'(i);
            chk($sformatf("%s_araddr%0d", name, i), (i < ar_addr_q.size()) ? ar_addr_q[i] : 'x, ea);
            chk($sformatf("%s_arid%0d", name, i), (i < ar_id_q.size()) ? ar_id_q[i] : 'x, ID_W'(i));
            chk($sformatf("%s_arlen%0d", name, i), (i < ar_len_q.size()) ? ar_len_q[i] : 'x, len);
        end
        chk({name, "_wr_count"}, wr_addr_q.size(), total);
        for (int k = 0; k < total; k++) begin
            ew = ram + RAM_AW'(k);
            chk($sformatf("%s_wr_addr%0d", name, k), (k < wr_addr_q.size()) ? wr_addr_q[k] : 'x, ew);
            chk($sformatf("%s_wr_data%0d", name, k), (k < wr_data_q.size()) ? wr_data_q[k] : 'x,
                (k < beat_data_q.size()) ? beat_data_q[k] : 64'h0);
        end
        chk({name, "_done_latency"}, done_cyc, last_beat_cyc + 1);
        chk({name, "_err_at_done"}, done_err, err_exp);
        chk({name, "_err_sticky"}, ld_err, err_exp);
        chk({name, "_rdy_at_done"}, rdy_at_done, 1'b0);
        chk({name, "_rdy_after_done"}, rdy_after_done, 1'b1);
        chk({name, "_outs_bound"}, outs_max <= MAX_OUTS, 1'b1);
        $display("cmd %s: addr=0x%0h num=%0d len=%0d stride=0x%0h ram=0x%0h ars=%0d writes=%0d outs_max=%0d err=%0b",
                 name, addr, num, len, stride, ram, ar_addr_q.size(), wr_addr_q.size(), outs_max, ld_err);
    endtask

    initial begin
        logic exp_rid_err;
        rst_n = 1'b0;
        cmd_vld = 1'b0;
        cmd_dram_addr = '0; cmd_num = '0; cmd_len = '0; cmd_stride = '0; cmd_ram_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_cmd("single", 31'h100, 8'd0, 8'd3, 31'h0, 12'h010, 0, 0, -1, 0);

        run_cmd("strided", 31'h0, 8'd5, 8'd1, 31'h40, 12'h200, 10, 0, -1, 0);
        chk("strided_outs_max", outs_max, MAX_OUTS);

        run_cmd("simul", 31'h1000, 8'd7, 8'd0, 31'h10, 12'h300, 2, 0, -1, 0);
        chk("simul_overlap_seen", both_cnt > 0, 1'b1);

        run_cmd("wrap", 31'h2000, 8'd0, 8'd3, 31'h0, 12'hFFE, 1, 0, -1, 0);
        chk("wrap_third_addr", (wr_addr_q.size() > 2) ? wr_addr_q[2] : 'x, 12'h000);

        run_cmd("err", 31'h3000, 8'd1, 8'd3, 31'h100, 12'h040, 0, 0, 2, 0);
        chk("err_flag_set", ld_err, 1'b1);

`ifdef LSU_RD_RID_CHECK_EN
        exp_rid_err = 1'b1;
`else
        exp_rid_err = 1'b0;
`endif
        run_cmd("rid", 31'h4000, 8'd1, 8'd1, 31'h80, 12'h080, 0, 0, -1, 1);
        chk("rid_err", ld_err, exp_rid_err);

        // Reset in the middle of a multi-burst load
        rdelay = 0; arrdy_rand = 0; err_beat = -1; rid_bad = 0;
        issue_cmd(31'h5000, 8'd3, 8'd7, 31'h200, 12'h100);
        repeat (5) @(posedge clk);
        #2;
        chk("midrst_busy", cmd_rdy, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_after_rdy", cmd_rdy, 1'b1);
        $display("cmd midrst: reset asserted mid-burst, cmd_rdy=%0b", cmd_rdy);

        for (int r = 0; r < 6; r++) begin
            logic [7:0] n, l;
            int tot, eb;
            n = 8'($urandom_range(0, 5));
            l = 8'($urandom_range(0, 7));
            tot = (int'(n) + 1) * (int'(l) + 1);
            eb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, tot - 1)) : -1;
            run_cmd($sformatf("rand%0d", r), ADDR_W'($urandom), n, l, ADDR_W'($urandom),
                    RAM_AW'($urandom), int'($urandom_range(0, 12)), 1, eb, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
